// File: rtl/alb_mss_fab_axi2ibp_rg.sv
// AXI3 slave to IBP initiator bridge with region support.
// AR and AW share the single IBP command channel through a round-robin arbiter.
// IBP responses carry no ID, so accepted command IDs are queued in order per direction.
module alb_mss_fab_axi2ibp_rg #(
    parameter int unsigned ID_W          = 4,
    parameter int unsigned RGON_W        = 4,
    parameter int unsigned ADDR_W        = 32,
    parameter int unsigned DATA_W        = 32,
    parameter int unsigned OUT_CMD_NUM   = 8,
    parameter int unsigned OUT_CMD_CNT_W = 3
) (
    input  logic                clk,
    input  logic                rst_a,
    input  logic                bus_clk_en,
    // AXI read command
    input  logic                axi_arvalid,
    output logic                axi_arready,
    input  logic [ID_W-1:0]     axi_arid,
    input  logic [ADDR_W-1:0]   axi_araddr,
    input  logic [RGON_W-1:0]   axi_arregion,
    input  logic [3:0]          axi_arlen,
    input  logic [2:0]          axi_arsize,
    input  logic [1:0]          axi_arburst,
    input  logic [1:0]          axi_arlock,
    input  logic [3:0]          axi_arcache,
    input  logic [2:0]          axi_arprot,
    // AXI write command
    input  logic                axi_awvalid,
    output logic                axi_awready,
    input  logic [ID_W-1:0]     axi_awid,
    input  logic [ADDR_W-1:0]   axi_awaddr,
    input  logic [RGON_W-1:0]   axi_awregion,
    input  logic [3:0]          axi_awlen,
    input  logic [2:0]          axi_awsize,
    input  logic [1:0]          axi_awburst,
    input  logic [1:0]          axi_awlock,
    input  logic [3:0]          axi_awcache,
    input  logic [2:0]          axi_awprot,
    // AXI write data
    input  logic                axi_wvalid,
    output logic                axi_wready,
    input  logic [DATA_W-1:0]   axi_wdata,
    input  logic [DATA_W/8-1:0] axi_wstrb,
    input  logic                axi_wlast,
    // AXI read data
    output logic                axi_rvalid,
    input  logic                axi_rready,
    output logic [ID_W-1:0]     axi_rid,
    output logic [DATA_W-1:0]   axi_rdata,
    output logic [1:0]          axi_rresp,
    output logic                axi_rlast,
    // AXI write response
    output logic                axi_bvalid,
    input  logic                axi_bready,
    output logic [ID_W-1:0]     axi_bid,
    output logic [1:0]          axi_bresp,
    // IBP command
    output logic                ibp_cmd_valid,
    input  logic                ibp_cmd_accept,
    output logic                ibp_cmd_read,
    output logic [ADDR_W-1:0]   ibp_cmd_addr,
    output logic [RGON_W-1:0]   ibp_cmd_region,
    output logic                ibp_cmd_wrap,
    output logic [2:0]          ibp_cmd_data_size,
    output logic [3:0]          ibp_cmd_burst_size,
    output logic                ibp_cmd_lock,
    output logic                ibp_cmd_excl,
    output logic [1:0]          ibp_cmd_prot,
    output logic [3:0]          ibp_cmd_cache,
    // IBP read data
    input  logic                ibp_rd_valid,
    output logic                ibp_rd_accept,
    input  logic [DATA_W-1:0]   ibp_rd_data,
    input  logic                ibp_rd_last,
    input  logic                ibp_err_rd,
    input  logic                ibp_rd_excl_ok,
    // IBP write data
    output logic                ibp_wr_valid,
    input  logic                ibp_wr_accept,
    output logic [DATA_W-1:0]   ibp_wr_data,
    output logic [DATA_W/8-1:0] ibp_wr_mask,
    output logic                ibp_wr_last,
    // IBP write response
    input  logic                ibp_wr_done,
    input  logic                ibp_wr_excl_done,
    input  logic                ibp_err_wr,
    output logic                ibp_wr_resp_accept
);

    localparam int unsigned CNT_W = OUT_CMD_CNT_W + 1;

    // Pointer increment that wraps at OUT_CMD_NUM, which need not be a power of two
    function automatic logic [OUT_CMD_CNT_W-1:0] ptr_inc(input logic [OUT_CMD_CNT_W-1:0] p);
        if (p == OUT_CMD_CNT_W'(OUT_CMD_NUM - 1)) begin
            return '0;
        end
        return p + 1'b1;
    endfunction

    // Read ID FIFO
    logic [ID_W:0]          rd_mem [OUT_CMD_NUM];
    logic [OUT_CMD_CNT_W-1:0] rd_wptr, rd_rptr;
    logic [CNT_W-1:0]       rd_cnt;
    logic                   rd_full, rd_empty, rd_push, rd_pop;
    logic [ID_W:0]          rd_head;

    // Write ID FIFO
    logic [ID_W:0]          wr_mem [OUT_CMD_NUM];
    logic [OUT_CMD_CNT_W-1:0] wr_wptr, wr_rptr;
    logic [CNT_W-1:0]       wr_cnt;
    logic                   wr_full, wr_empty, wr_push, wr_pop;
    logic [ID_W:0]          wr_head;

    // Arbitration and write credit
    logic                   rr_wr;      // 1: write has priority on the next tie
    logic                   rd_elig, wr_elig, sel_rd, sel_wr;
    logic [CNT_W-1:0]       wcredit;
    logic                   has_credit, w_last_hs;
    logic                   unused_ok;

    assign unused_ok = ^{axi_arprot[1], axi_awprot[1]};

    assign rd_full  = (rd_cnt == CNT_W'(OUT_CMD_NUM));
    assign rd_empty = (rd_cnt == '0);
    assign wr_full  = (wr_cnt == CNT_W'(OUT_CMD_NUM));
    assign wr_empty = (wr_cnt == '0);

    assign rd_elig = axi_arvalid & ~rd_full;
    assign wr_elig = axi_awvalid & ~wr_full;
    assign sel_rd  = rd_elig & (~wr_elig | ~rr_wr);
    assign sel_wr  = wr_elig & (~rd_elig | rr_wr);

    assign ibp_cmd_valid = rst_a & (rd_elig | wr_elig);
    assign axi_arready   = rst_a & sel_rd & ibp_cmd_accept & bus_clk_en;
    assign axi_awready   = rst_a & sel_wr & ibp_cmd_accept & bus_clk_en;
    assign ibp_cmd_read  = sel_rd;

    assign rd_push = axi_arready;
    assign wr_push = axi_awready;

    // Command field mux: the winning channel drives every IBP command field
    always_comb begin
        if (sel_rd) begin
            ibp_cmd_addr       = axi_araddr;
            ibp_cmd_region     = axi_arregion;
            ibp_cmd_wrap       = (axi_arburst == 2'b10);
            ibp_cmd_data_size  = axi_arsize;
            ibp_cmd_burst_size = axi_arlen;
            ibp_cmd_lock       = (axi_arlock == 2'b10);
            ibp_cmd_excl       = (axi_arlock == 2'b01);
            ibp_cmd_prot       = {axi_arprot[2], axi_arprot[0]};
            ibp_cmd_cache      = axi_arcache;
        end else begin
            ibp_cmd_addr       = axi_awaddr;
            ibp_cmd_region     = axi_awregion;
            ibp_cmd_wrap       = (axi_awburst == 2'b10);
            ibp_cmd_data_size  = axi_awsize;
            ibp_cmd_burst_size = axi_awlen;
            ibp_cmd_lock       = (axi_awlock == 2'b10);
            ibp_cmd_excl       = (axi_awlock == 2'b01);
            ibp_cmd_prot       = {axi_awprot[2], axi_awprot[0]};
            ibp_cmd_cache      = axi_awcache;
        end
    end

    // Round-robin pointer flips on every accepted command
    always_ff @(posedge clk or negedge rst_a) begin
        if (!rst_a) begin
            rr_wr <= 1'b0;
        end else if (bus_clk_en && (rd_push || wr_push)) begin
            rr_wr <= ~rr_wr;
        end
    end

    // Write data: only released once its AW has been accepted (credit non-zero)
    assign has_credit   = (wcredit != '0);
    assign ibp_wr_valid = rst_a & axi_wvalid & has_credit;
    assign axi_wready   = rst_a & ibp_wr_accept & has_credit & bus_clk_en;
    assign ibp_wr_data  = axi_wdata;
    assign ibp_wr_mask  = axi_wstrb;
    assign ibp_wr_last  = axi_wlast;
    assign w_last_hs    = axi_wvalid & axi_wready & axi_wlast;

    // Write credit: +1 per accepted AW, -1 per completed W burst
    always_ff @(posedge clk or negedge rst_a) begin
        if (!rst_a) begin
            wcredit <= '0;
        end else if (bus_clk_en) begin
            if (wr_push && !w_last_hs) begin
                wcredit <= wcredit + 1'b1;
            end else if (!wr_push && w_last_hs) begin
                wcredit <= wcredit - 1'b1;
            end
        end
    end

    // Read data path; ID and exclusive flag come from the oldest outstanding read
    assign rd_head       = rd_mem[rd_rptr];
    assign axi_rvalid    = ibp_rd_valid;
    assign ibp_rd_accept = axi_rready & bus_clk_en;
    assign axi_rdata     = ibp_rd_data;
    assign axi_rlast     = ibp_rd_last;
    assign axi_rid       = rd_empty ? '0 : rd_head[ID_W:1];
    assign axi_rresp     = ibp_err_rd ? 2'b10 :
                           ((~rd_empty & rd_head[0] & ibp_rd_excl_ok) ? 2'b01 : 2'b00);
    assign rd_pop        = ibp_rd_valid & ibp_rd_accept & ibp_rd_last & ~rd_empty;

    // Write response path
    assign wr_head            = wr_mem[wr_rptr];
    assign axi_bvalid         = ibp_wr_done | ibp_wr_excl_done | ibp_err_wr;
    assign ibp_wr_resp_accept = axi_bready & bus_clk_en;
    assign axi_bid            = wr_empty ? '0 : wr_head[ID_W:1];
    assign axi_bresp          = ibp_err_wr ? 2'b10 : (ibp_wr_excl_done ? 2'b01 : 2'b00);
    assign wr_pop             = axi_bvalid & ibp_wr_resp_accept & ~wr_empty;

    // Read FIFO pointers and occupancy; no bypass, so a full FIFO stays full this cycle
    always_ff @(posedge clk or negedge rst_a) begin
        if (!rst_a) begin
            rd_wptr <= '0;
            rd_rptr <= '0;
            rd_cnt  <= '0;
        end else if (bus_clk_en) begin
            if (rd_push) rd_wptr <= ptr_inc(rd_wptr);
            if (rd_pop)  rd_rptr <= ptr_inc(rd_rptr);
            if (rd_push && !rd_pop) begin
                rd_cnt <= rd_cnt + 1'b1;
            end else if (!rd_push && rd_pop) begin
                rd_cnt <= rd_cnt - 1'b1;
            end
        end
    end

    // Read FIFO storage: {id, excl}
    always_ff @(posedge clk) begin
        if (bus_clk_en && rd_push) begin
            rd_mem[rd_wptr] <= {axi_arid, (axi_arlock == 2'b01)};
        end
    end

    // Write FIFO pointers and occupancy
    always_ff @(posedge clk or negedge rst_a) begin
        if (!rst_a) begin
            wr_wptr <= '0;
            wr_rptr <= '0;
            wr_cnt  <= '0;
        end else if (bus_clk_en) begin
            if (wr_push) wr_wptr <= ptr_inc(wr_wptr);
            if (wr_pop)  wr_rptr <= ptr_inc(wr_rptr);
            if (wr_push && !wr_pop) begin
                wr_cnt <= wr_cnt + 1'b1;
            end else if (!wr_push && wr_pop) begin
                wr_cnt <= wr_cnt - 1'b1;
            end
        end
    end

    // Write FIFO storage: {id, excl}
    always_ff @(posedge clk) begin
        if (bus_clk_en && wr_push) begin
            wr_mem[wr_wptr] <= {axi_awid, (axi_awlock == 2'b01)};
        end
    end

    // A response with nothing outstanding is a protocol error on the IBP side
    a_rd_resp_has_cmd: assert property (@(posedge clk) disable iff (!rst_a)
        !(ibp_rd_valid && rd_empty));
    a_wr_resp_has_cmd: assert property (@(posedge clk) disable iff (!rst_a)
        !(axi_bvalid && wr_empty));

endmodule

// File: tb/tb_alb_mss_fab_axi2ibp_rg.sv
// Randomized bench for the AXI3-to-IBP region bridge against a queue-based reference model.
module tb_alb_mss_fab_axi2ibp_rg;

    localparam int NUM = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_a, bus_clk_en;
    logic axi_arvalid, axi_arready; logic [3:0] axi_arid; logic [31:0] axi_araddr;
    logic [3:0] axi_arregion, axi_arlen, axi_arcache; logic [2:0] axi_arsize, axi_arprot;
    logic [1:0] axi_arburst, axi_arlock;
    logic axi_awvalid, axi_awready; logic [3:0] axi_awid; logic [31:0] axi_awaddr;
    logic [3:0] axi_awregion, axi_awlen, axi_awcache; logic [2:0] axi_awsize, axi_awprot;
    logic [1:0] axi_awburst, axi_awlock;
    logic axi_wvalid, axi_wready, axi_wlast; logic [31:0] axi_wdata; logic [3:0] axi_wstrb;
    logic axi_rvalid, axi_rready, axi_rlast; logic [3:0] axi_rid; logic [31:0] axi_rdata;
    logic [1:0] axi_rresp;
    logic axi_bvalid, axi_bready; logic [3:0] axi_bid; logic [1:0] axi_bresp;
    logic ibp_cmd_valid, ibp_cmd_accept, ibp_cmd_read, ibp_cmd_wrap, ibp_cmd_lock, ibp_cmd_excl;
    logic [31:0] ibp_cmd_addr; logic [3:0] ibp_cmd_region, ibp_cmd_burst_size, ibp_cmd_cache;
    logic [2:0] ibp_cmd_data_size; logic [1:0] ibp_cmd_prot;
    logic ibp_rd_valid, ibp_rd_accept, ibp_rd_last, ibp_err_rd, ibp_rd_excl_ok;
    logic [31:0] ibp_rd_data;
    logic ibp_wr_valid, ibp_wr_accept, ibp_wr_last; logic [31:0] ibp_wr_data;
    logic [3:0] ibp_wr_mask;
    logic ibp_wr_done, ibp_wr_excl_done, ibp_err_wr, ibp_wr_resp_accept;

    alb_mss_fab_axi2ibp_rg dut (
        .clk(clk), .rst_a(rst_a), .bus_clk_en(bus_clk_en),
        .axi_arvalid(axi_arvalid), .axi_arready(axi_arready), .axi_arid(axi_arid),
        .axi_araddr(axi_araddr), .axi_arregion(axi_arregion), .axi_arlen(axi_arlen),
        .axi_arsize(axi_arsize), .axi_arburst(axi_arburst), .axi_arlock(axi_arlock),
        .axi_arcache(axi_arcache), .axi_arprot(axi_arprot),
        .axi_awvalid(axi_awvalid), .axi_awready(axi_awready), .axi_awid(axi_awid),
        .axi_awaddr(axi_awaddr), .axi_awregion(axi_awregion), .axi_awlen(axi_awlen),
        .axi_awsize(axi_awsize), .axi_awburst(axi_awburst), .axi_awlock(axi_awlock),
        .axi_awcache(axi_awcache), .axi_awprot(axi_awprot),
        .axi_wvalid(axi_wvalid), .axi_wready(axi_wready), .axi_wdata(axi_wdata),
        .axi_wstrb(axi_wstrb), .axi_wlast(axi_wlast),
        .axi_rvalid(axi_rvalid), .axi_rready(axi_rready), .axi_rid(axi_rid),
        .axi_rdata(axi_rdata), .axi_rresp(axi_rresp), .axi_rlast(axi_rlast),
        .axi_bvalid(axi_bvalid), .axi_bready(axi_bready), .axi_bid(axi_bid),
        .axi_bresp(axi_bresp),
        .ibp_cmd_valid(ibp_cmd_valid), .ibp_cmd_accept(ibp_cmd_accept),
        .ibp_cmd_read(ibp_cmd_read), .ibp_cmd_addr(ibp_cmd_addr),
        .ibp_cmd_region(ibp_cmd_region), .ibp_cmd_wrap(ibp_cmd_wrap),
        .ibp_cmd_data_size(ibp_cmd_data_size), .ibp_cmd_burst_size(ibp_cmd_burst_size),
        .ibp_cmd_lock(ibp_cmd_lock), .ibp_cmd_excl(ibp_cmd_excl), .ibp_cmd_prot(ibp_cmd_prot),
        .ibp_cmd_cache(ibp_cmd_cache),
        .ibp_rd_valid(ibp_rd_valid), .ibp_rd_accept(ibp_rd_accept),
        .ibp_rd_data(ibp_rd_data), .ibp_rd_last(ibp_rd_last), .ibp_err_rd(ibp_err_rd),
        .ibp_rd_excl_ok(ibp_rd_excl_ok),
        .ibp_wr_valid(ibp_wr_valid), .ibp_wr_accept(ibp_wr_accept),
        .ibp_wr_data(ibp_wr_data), .ibp_wr_mask(ibp_wr_mask), .ibp_wr_last(ibp_wr_last),
        .ibp_wr_done(ibp_wr_done), .ibp_wr_excl_done(ibp_wr_excl_done),
        .ibp_err_wr(ibp_err_wr), .ibp_wr_resp_accept(ibp_wr_resp_accept)
    );

    // Reference model: outstanding commands in acceptance order
    typedef struct packed { logic [3:0] id; logic excl; } ent_t;
    ent_t rq[$];
    ent_t wq[$];
    int   wcredit;
    bit   rr_wr;

    int n_checks = 0;
    int n_fail   = 0;

    // Knobs (percent chances) and run state
    int p_ar, p_aw, p_w, p_acc, p_rd, p_rready, p_b, p_bready, p_en;
    int en_mode = 0;
    int cyc = 0;
    bit rst_drv = 1'b0;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic bit chance(input int p);
        return int'($urandom_range(0, 99)) < p;
    endfunction

    task automatic set_knobs(input int ar, input int aw, input int w, input int acc,
                             input int rd, input int rr, input int b, input int en);
        p_ar = ar; p_aw = aw; p_w = w; p_acc = acc; p_rd = rd; p_rready = rr;
        p_b = b; p_bready = 70; p_en = en;
    endtask

    // One cycle: drive at negedge, check outputs, then advance the model for the posedge
    task automatic step();
        bit r_ok, w_ok, sel_r, sel_w, ar_hs, aw_hs, nz, exp_wready, exp_racc, exp_bacc, hx;
        logic [3:0] hid, bhid;
        logic [1:0] rr_exp, br_exp;
        int k;
        @(negedge clk);
        cyc++;
        rst_a = rst_drv;
        if (!rst_a) begin
            rq.delete(); wq.delete(); wcredit = 0; rr_wr = 1'b0;
        end
        bus_clk_en = (en_mode == 1) ? (cyc % 3 == 0) : chance(p_en);

        axi_arvalid = chance(p_ar); axi_arid = 4'($urandom); axi_araddr = $urandom;
        axi_arregion = 4'($urandom); axi_arlen = 4'($urandom); axi_arsize = 3'($urandom);
        axi_arburst = 2'($urandom); axi_arlock = 2'($urandom); axi_arcache = 4'($urandom);
        axi_arprot = 3'($urandom);
        axi_awvalid = chance(p_aw); axi_awid = 4'($urandom); axi_awaddr = $urandom;
        axi_awregion = 4'($urandom); axi_awlen = 4'($urandom); axi_awsize = 3'($urandom);
        axi_awburst = 2'($urandom); axi_awlock = 2'($urandom); axi_awcache = 4'($urandom);
        axi_awprot = 3'($urandom);
        axi_wvalid = chance(p_w); axi_wdata = $urandom; axi_wstrb = 4'($urandom);
        axi_wlast = chance(50);
        ibp_cmd_accept = chance(p_acc); ibp_wr_accept = chance(80);
        axi_rready = chance(p_rready); axi_bready = chance(p_bready);

        ibp_rd_valid = rst_a && rq.size() > 0 && chance(p_rd);
        ibp_rd_data = $urandom; ibp_rd_last = chance(40); ibp_err_rd = chance(15);
        ibp_rd_excl_ok = chance(50);
        // Only writes whose data has fully passed may be answered
        ibp_wr_done = 0; ibp_wr_excl_done = 0; ibp_err_wr = 0;
        if (rst_a && wq.size() > wcredit && chance(p_b)) begin
            k = int'($urandom_range(0, 2));
            if (k == 0) ibp_wr_done = 1; else if (k == 1) ibp_wr_excl_done = 1;
            else ibp_err_wr = 1;
        end
        #1;

        r_ok  = axi_arvalid && rq.size() < NUM;
        w_ok  = axi_awvalid && wq.size() < NUM;
        sel_r = (r_ok && w_ok) ? !rr_wr : r_ok;
        sel_w = (r_ok || w_ok) && !sel_r;
        ar_hs = rst_a && sel_r && ibp_cmd_accept && bus_clk_en;
        aw_hs = rst_a && sel_w && ibp_cmd_accept && bus_clk_en;
        check("cmd_valid", ibp_cmd_valid, rst_a && (r_ok || w_ok));
        if (rst_a && (r_ok || w_ok)) begin
            if (sel_r)
                check("cmd_rd", {ibp_cmd_read, ibp_cmd_addr, ibp_cmd_region, ibp_cmd_wrap,
                    ibp_cmd_data_size, ibp_cmd_burst_size, ibp_cmd_lock, ibp_cmd_excl,
                    ibp_cmd_prot, ibp_cmd_cache},
                    {1'b1, axi_araddr, axi_arregion, axi_arburst == 2'b10, axi_arsize,
                    axi_arlen, axi_arlock == 2'b10, axi_arlock == 2'b01,
                    axi_arprot[2], axi_arprot[0], axi_arcache});
            else
                check("cmd_wr", {ibp_cmd_read, ibp_cmd_addr, ibp_cmd_region, ibp_cmd_wrap,
                    ibp_cmd_data_size, ibp_cmd_burst_size, ibp_cmd_lock, ibp_cmd_excl,
                    ibp_cmd_prot, ibp_cmd_cache},
                    {1'b0, axi_awaddr, axi_awregion, axi_awburst == 2'b10, axi_awsize,
                    axi_awlen, axi_awlock == 2'b10, axi_awlock == 2'b01,
                    axi_awprot[2], axi_awprot[0], axi_awcache});
        end
        check("axready", {axi_arready, axi_awready}, {ar_hs, aw_hs});

        nz = (wcredit != 0);
        exp_wready = rst_a && ibp_wr_accept && nz && bus_clk_en;
        check("w_chan", {ibp_wr_valid, axi_wready, ibp_wr_data, ibp_wr_mask, ibp_wr_last},
              {rst_a && axi_wvalid && nz, exp_wready, axi_wdata, axi_wstrb, axi_wlast});

        hid = (rq.size() > 0) ? rq[0].id : 4'd0;
        hx  = (rq.size() > 0) ? rq[0].excl : 1'b0;
        rr_exp = ibp_err_rd ? 2'b10 : ((hx && ibp_rd_excl_ok) ? 2'b01 : 2'b00);
        exp_racc = axi_rready && bus_clk_en;
        check("r_chan", {axi_rvalid, ibp_rd_accept, axi_rid, axi_rdata, axi_rresp, axi_rlast},
              {ibp_rd_valid, exp_racc, hid, ibp_rd_data, rr_exp, ibp_rd_last});

        bhid = (wq.size() > 0) ? wq[0].id : 4'd0;
        br_exp = ibp_err_wr ? 2'b10 : (ibp_wr_excl_done ? 2'b01 : 2'b00);
        exp_bacc = axi_bready && bus_clk_en;
        check("b_chan", {axi_bvalid, ibp_wr_resp_accept, axi_bid, axi_bresp},
              {ibp_wr_done || ibp_wr_excl_done || ibp_err_wr, exp_bacc, bhid, br_exp});

        if (rst_a) begin
            if (ibp_rd_valid && exp_racc && ibp_rd_last) void'(rq.pop_front());
            if ((ibp_wr_done || ibp_wr_excl_done || ibp_err_wr) && exp_bacc)
                void'(wq.pop_front());
            if (ar_hs) rq.push_back('{id: axi_arid, excl: axi_arlock == 2'b01});
            if (aw_hs) begin
                wq.push_back('{id: axi_awid, excl: axi_awlock == 2'b01});
                wcredit++;
            end
            if (axi_wvalid && exp_wready && axi_wlast) wcredit--;
            if (ar_hs || aw_hs) rr_wr = !rr_wr;
        end
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        rst_a = 1'b0;
        // Reset: readies and valids low with traffic requested
        set_knobs(100, 100, 100, 100, 0, 50, 0, 100);
        rst_drv = 1'b0; run(3);
        rst_drv = 1'b1;
        // Both commands always valid: strict R,W alternation from reset
        set_knobs(100, 100, 0, 100, 0, 100, 0, 100);
        run(6);
        // Fill the read FIFO with no read data returning, writes still flowing
        set_knobs(100, 40, 60, 100, 0, 100, 50, 100);
        run(25);
        // Drain reads while new ones keep arriving
        set_knobs(100, 40, 60, 100, 60, 80, 50, 100);
        run(25);
        // General random traffic
        set_knobs(60, 60, 60, 70, 50, 70, 50, 85);
        run(500);
        // Clock enable only one cycle in three
        en_mode = 1;
        set_knobs(70, 70, 70, 80, 50, 80, 50, 100);
        run(150);
        en_mode = 0;
        // Reset in the middle of traffic, then recover
        set_knobs(60, 60, 60, 70, 30, 70, 40, 90);
        run(40);
        rst_drv = 1'b0; run(2);
        rst_drv = 1'b1; run(300);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
